id_ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-select stage of the RISC-V core, sitting directly upstream of the ALU. It captures decoded fields from the decode stage each cycle, holds them on stall, bubbles them on flush, and drives `ALU_Src_A`, `ALU_Src_B` and `ALUControl` into the ALU. Operand selection is combinational from the registered fields plus the live MEM/WB buses, with forwarding. It also raises a load-use stall request to the hazard logic.

---
 rtl/id_ex_operand_stage.sv | 149 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand selection, MEM/WB forwarding and
// load-use stall detection, feeding the ALU directly.
module id_ex_operand_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET_n,
    input  logic            Stall,
    input  logic            Flush,
    input  logic            Valid_D,
    input  logic [XLEN-1:0] PC_D,
    input  logic [XLEN-1:0] Imm_D,
    input  logic [XLEN-1:0] RD1_D,
    input  logic [XLEN-1:0] RD2_D,
    input  logic [4:0]      Rs1_D,
    input  logic [4:0]      Rs2_D,
    input  logic [4:0]      Rd_D,
    input  logic [1:0]      ALUControl_D,
    input  logic            ALUSrcA_D,
    input  logic            ALUSrcB_D,
    input  logic            RegWrite_D,
    input  logic            MemRead_D,
    input  logic            MemWrite_D,
    input  logic [4:0]      Rd_M,
    input  logic [4:0]      Rd_W,
    input  logic            RegWrite_M,
    input  logic            RegWrite_W,
    input  logic [XLEN-1:0] ALUResult_M,
    input  logic [XLEN-1:0] Result_W,
    output logic [XLEN-1:0] ALU_Src_A,
    output logic [XLEN-1:0] ALU_Src_B,
    output logic [1:0]      ALUControl,
    output logic [XLEN-1:0] WriteData_E,
    output logic [4:0]      Rd_E,
    output logic            RegWrite_E,
    output logic            MemRead_E,
    output logic            MemWrite_E,
    output logic            Valid_E,
    output logic            LoadUse_Stall
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] rd1_q;
    logic [XLEN-1:0] rd2_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic [1:0]      alu_ctl_q;
    logic            src_a_q;
    logic            src_b_q;
    logic            reg_write_q;
    logic            mem_read_q;
    logic            mem_write_q;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_ctl_q   <= '0;
            src_a_q     <= 1'b0;
            src_b_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (Flush) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_ctl_q   <= '0;
            src_a_q     <= 1'b0;
            src_b_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!Stall) begin
            valid_q     <= Valid_D;
            pc_q        <= PC_D;
            imm_q       <= Imm_D;
            rd1_q       <= RD1_D;
            rd2_q       <= RD2_D;
            rs1_q       <= Rs1_D;
            rs2_q       <= Rs2_D;
            rd_q        <= Rd_D;
            alu_ctl_q   <= ALUControl_D;
            src_a_q     <= ALUSrcA_D;
            src_b_q     <= ALUSrcB_D;
            // An invalid slot must never write state further down the pipe.
            reg_write_q <= RegWrite_D & Valid_D;
            mem_read_q  <= MemRead_D & Valid_D;
            mem_write_q <= MemWrite_D & Valid_D;
        end
    end

    // MEM result is younger than WB, so it wins when both match.
    always_comb begin
        fwd_a = rd1_q;
        if (RegWrite_M && (Rd_M == rs1_q) && (rs1_q != 5'd0)) begin
            fwd_a = ALUResult_M;
        end else if (RegWrite_W && (Rd_W == rs1_q) && (rs1_q != 5'd0)) begin
            fwd_a = Result_W;
        end

        fwd_b = rd2_q;
        if (RegWrite_M && (Rd_M == rs2_q) && (rs2_q != 5'd0)) begin
            fwd_b = ALUResult_M;
        end else if (RegWrite_W && (Rd_W == rs2_q) && (rs2_q != 5'd0)) begin
            fwd_b = Result_W;
        end
    end

    always_comb begin
        ALU_Src_A   = '0;
        ALU_Src_B   = '0;
        WriteData_E = '0;
        ALUControl  = 2'b00;
        if (valid_q) begin
            ALU_Src_A   = src_a_q ? pc_q : fwd_a;
            ALU_Src_B   = src_b_q ? imm_q : fwd_b;
            WriteData_E = fwd_b;
            ALUControl  = alu_ctl_q;
        end
    end

    assign Rd_E       = rd_q;
    assign RegWrite_E = reg_write_q;
    assign MemRead_E  = mem_read_q;
    assign MemWrite_E = mem_write_q;
    assign Valid_E    = valid_q;

    assign LoadUse_Stall = valid_q & mem_read_q & (rd_q != 5'd0) & Valid_D
                         & ((rd_q == Rs1_D) | (rd_q == Rs2_D));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: a transaction-level model checked
// every negative clock edge, plus literal expectations at key points.
module tb_id_ex_operand_stage;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        Stall, Flush, Valid_D;
    logic [31:0] PC_D, Imm_D, RD1_D, RD2_D;
    logic [4:0]  Rs1_D, Rs2_D, Rd_D;
    logic [1:0]  ALUControl_D;
    logic        ALUSrcA_D, ALUSrcB_D, RegWrite_D, MemRead_D, MemWrite_D;
    logic [4:0]  Rd_M, Rd_W;
    logic        RegWrite_M, RegWrite_W;
    logic [31:0] ALUResult_M, Result_W;
    logic [31:0] ALU_Src_A, ALU_Src_B, WriteData_E;
    logic [1:0]  ALUControl;
    logic [4:0]  Rd_E;
    logic        RegWrite_E, MemRead_E, MemWrite_E, Valid_E, LoadUse_Stall;

    int ncmp = 0;
    int nfail = 0;

    id_ex_operand_stage #(.XLEN(32)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .Stall(Stall), .Flush(Flush),
        .Valid_D(Valid_D), .PC_D(PC_D), .Imm_D(Imm_D), .RD1_D(RD1_D),
        .RD2_D(RD2_D), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
        .ALUControl_D(ALUControl_D), .ALUSrcA_D(ALUSrcA_D),
        .ALUSrcB_D(ALUSrcB_D), .RegWrite_D(RegWrite_D),
        .MemRead_D(MemRead_D), .MemWrite_D(MemWrite_D), .Rd_M(Rd_M),
        .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .ALUResult_M(ALUResult_M), .Result_W(Result_W),
        .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALUControl(ALUControl),
        .WriteData_E(WriteData_E), .Rd_E(Rd_E), .RegWrite_E(RegWrite_E),
        .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E), .Valid_E(Valid_E),
        .LoadUse_Stall(LoadUse_Stall)
    );

    always #5 CLK = ~CLK;

    // The instruction the model believes occupies the EX slot.
    typedef struct packed {
        logic        v;
        logic [31:0] pc, imm, rd1, rd2;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  ctl;
        logic        sa, sb, rw, mr, mw;
    } ins_t;

    ins_t m = '0;

    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) m <= '0;
        else if (Flush) m <= '0;
        else if (!Stall)
            m <= '{v: Valid_D, pc: PC_D, imm: Imm_D, rd1: RD1_D, rd2: RD2_D,
                   rs1: Rs1_D, rs2: Rs2_D, rd: Rd_D, ctl: ALUControl_D,
                   sa: ALUSrcA_D, sb: ALUSrcB_D, rw: RegWrite_D && Valid_D,
                   mr: MemRead_D && Valid_D, mw: MemWrite_D && Valid_D};
    end

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] regval,
                                            input logic mw_en, input logic [4:0] mrd,
                                            input logic [31:0] mval, input logic ww_en,
                                            input logic [4:0] wrd, input logic [31:0] wval);
        if (r == 0) return regval;
        if (mw_en && mrd == r) return mval;
        if (ww_en && wrd == r) return wval;
        return regval;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic [31:0] fa, fb, ea, eb, ew;
        logic        lu;
        fa = operand(m.rs1, m.rd1, RegWrite_M, Rd_M, ALUResult_M, RegWrite_W, Rd_W, Result_W);
        fb = operand(m.rs2, m.rd2, RegWrite_M, Rd_M, ALUResult_M, RegWrite_W, Rd_W, Result_W);
        ea = m.v ? (m.sa ? m.pc : fa) : 32'd0;
        eb = m.v ? (m.sb ? m.imm : fb) : 32'd0;
        ew = m.v ? fb : 32'd0;
        lu = m.v && m.mr && m.rd != 0 && Valid_D && (m.rd == Rs1_D || m.rd == Rs2_D);
        chk("model_src_a", ALU_Src_A, ea);
        chk("model_src_b", ALU_Src_B, eb);
        chk("model_wdata", WriteData_E, ew);
        chk("model_ctl", {30'd0, ALUControl}, m.v ? {30'd0, m.ctl} : 32'd0);
        chk("model_rd", {27'd0, Rd_E}, {27'd0, m.rd});
        chk("model_ctrl", {28'd0, Valid_E, RegWrite_E, MemRead_E, MemWrite_E},
            {28'd0, m.v, m.rw, m.mr, m.mw});
        chk("model_loaduse", {31'd0, LoadUse_Stall}, {31'd0, lu});
    end

    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_d();
        Valid_D = 0; PC_D = 0; Imm_D = 0; RD1_D = 0; RD2_D = 0;
        Rs1_D = 0; Rs2_D = 0; Rd_D = 0; ALUControl_D = 0;
        ALUSrcA_D = 0; ALUSrcB_D = 0; RegWrite_D = 0; MemRead_D = 0; MemWrite_D = 0;
    endtask

    initial begin
        RESET_n = 0; Stall = 0; Flush = 0;
        clear_d();
        Rd_M = 0; Rd_W = 0; RegWrite_M = 0; RegWrite_W = 0;
        ALUResult_M = 0; Result_W = 0;
        edge_step(); edge_step();
        chk("rst_src_a", ALU_Src_A, 0);
        chk("rst_src_b", ALU_Src_B, 0);
        chk("rst_valid", {31'd0, Valid_E}, 0);
        chk("rst_loaduse", {31'd0, LoadUse_Stall}, 0);
        RESET_n = 1;

        // Plain sub with no hazards
        Valid_D = 1; ALUControl_D = 2'b01; RD1_D = 10; RD2_D = 3;
        Rs1_D = 1; Rs2_D = 2; Rd_D = 3; RegWrite_D = 1;
        edge_step();
        chk("basic_a", ALU_Src_A, 10);
        chk("basic_b", ALU_Src_B, 3);
        chk("basic_ctl", {30'd0, ALUControl}, 1);
        chk("basic_valid", {31'd0, Valid_E}, 1);

        // Forwarding priority and x0
        Rs1_D = 5; RD1_D = 32'h55;
        edge_step();
        RegWrite_M = 1; Rd_M = 5; ALUResult_M = 32'h1234;
        RegWrite_W = 1; Rd_W = 5; Result_W = 32'h9;
        #1 chk("fwd_mem_prio", ALU_Src_A, 32'h1234);
        Rd_M = 0;
        #1 chk("fwd_wb", ALU_Src_A, 32'h9);
        Rs1_D = 0; RD1_D = 32'h77;
        edge_step();
        Rd_W = 0;
        #1 chk("fwd_x0", ALU_Src_A, 32'h77);
        chk("fwd_none_b", ALU_Src_B, 3);
        RegWrite_M = 0; RegWrite_W = 0;

        // PC / immediate operands
        ALUSrcA_D = 1; PC_D = 32'h100; ALUSrcB_D = 1; Imm_D = 32'hFFFFF800; RD2_D = 32'hAB;
        edge_step();
        chk("pc_a", ALU_Src_A, 32'h100);
        chk("imm_b", ALU_Src_B, 32'hFFFFF800);
        chk("imm_wdata", WriteData_E, 32'hAB);

        // Load then dependent instruction
        ALUSrcA_D = 0; MemRead_D = 1; Rd_D = 7; Imm_D = 4; Rs1_D = 1; RD1_D = 32'h1000;
        edge_step();
        MemRead_D = 0; ALUSrcB_D = 0; Rs1_D = 3; Rs2_D = 7; Rd_D = 8; RD2_D = 32'h50;
        #1 chk("loaduse_hit", {31'd0, LoadUse_Stall}, 1);
        Flush = 1;
        edge_step();
        Flush = 0;
        chk("bubble_valid", {31'd0, Valid_E}, 0);
        chk("bubble_a", ALU_Src_A, 0);
        chk("bubble_b", ALU_Src_B, 0);
        chk("bubble_loaduse", {31'd0, LoadUse_Stall}, 0);
        edge_step();
        RegWrite_W = 1; Rd_W = 7; Result_W = 32'hCAFE;
        #1 chk("load_fwd_b", ALU_Src_B, 32'hCAFE);
        chk("load_fwd_wd", WriteData_E, 32'hCAFE);
        RegWrite_W = 0;

        // Flush wins over stall, then a 3-cycle stall
        Stall = 1; Flush = 1;
        edge_step();
        Stall = 0; Flush = 0;
        chk("flush_over_stall", {31'd0, Valid_E}, 0);
        ALUControl_D = 2'b10; Rs1_D = 4; RD1_D = 32'h11; Rs2_D = 6; RD2_D = 32'h22; Rd_D = 9;
        edge_step();
        Stall = 1; RD1_D = 32'hEE; Rd_D = 12; ALUControl_D = 2'b11;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("stall_a", ALU_Src_A, 32'h11);
            chk("stall_ctl", {30'd0, ALUControl}, 2);
            chk("stall_rd", {27'd0, Rd_E}, 9);
        end
        RegWrite_W = 1; Rd_W = 4; Result_W = 32'h44;
        #1 chk("stall_wb_fwd", ALU_Src_A, 32'h44);
        Stall = 0; RegWrite_W = 0;

        // Invalid slot clears writes
        Valid_D = 0; RegWrite_D = 1; MemWrite_D = 1; MemRead_D = 1;
        edge_step();
        chk("inv_ctrl", {28'd0, Valid_E, RegWrite_E, MemRead_E, MemWrite_E}, 0);
        chk("inv_a", ALU_Src_A, 0);

        // Asynchronous reset between edges
        clear_d();
        Valid_D = 1; RD1_D = 32'h99; Rs1_D = 1; RegWrite_D = 1;
        edge_step();
        #2 RESET_n = 0;
        #1 chk("arst_a", ALU_Src_A, 0);
        chk("arst_ctrl", {28'd0, Valid_E, RegWrite_E, MemRead_E, MemWrite_E}, 0);
        @(negedge CLK); #1 RESET_n = 1;
        edge_step();
        chk("post_rst_valid", {31'd0, Valid_E}, 1);
        chk("post_rst_a", ALU_Src_A, 32'h99);

        // Short mixed run checked by the model only
        for (int i = 0; i < 40; i++) begin
            Valid_D = ($urandom_range(0, 3) != 0);
            PC_D = $urandom; Imm_D = $urandom; RD1_D = $urandom; RD2_D = $urandom;
            Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
            Rd_D = 5'($urandom_range(0, 3)); ALUControl_D = 2'($urandom_range(0, 3));
            ALUSrcA_D = 1'($urandom_range(0, 1)); ALUSrcB_D = 1'($urandom_range(0, 1));
            RegWrite_D = 1'($urandom_range(0, 1)); MemRead_D = 1'($urandom_range(0, 1));
            MemWrite_D = 1'($urandom_range(0, 1));
            Stall = ($urandom_range(0, 4) == 0); Flush = ($urandom_range(0, 5) == 0);
            Rd_M = 5'($urandom_range(0, 3)); Rd_W = 5'($urandom_range(0, 3));
            RegWrite_M = 1'($urandom_range(0, 1)); RegWrite_W = 1'($urandom_range(0, 1));
            ALUResult_M = $urandom; Result_W = $urandom;
            edge_step();
        end

        @(negedge CLK); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
